// File: rtl/irq_pending_ctrl.sv
// Interrupt pending/present controller: edge-detects req into sticky pending
// bits, presents one ID at a time to a consumer with ack, flags overruns.
// Ports: clk, rst_n (sync active-low); req[7:0], mask[7:0] in;
// pend_vec[7:0] out to ext priority encoder; enc_out[2:0], enc_valid in;
// irq_valid, irq_id[2:0] out; irq_ack in; ovf[7:0] out; ovf_clr in.
module irq_pending_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  output logic [7:0] pend_vec,
  input  logic [2:0] enc_out,
  input  logic       enc_valid,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  input  logic       irq_ack,
  output logic [7:0] ovf,
  input  logic       ovf_clr
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  logic [0:0] state, state_nx;
  logic [7:0] req_d;
  logic [7:0] pending;
  logic [7:0] rise;
  logic [7:0] clr;
  logic [7:0] ovr;
  logic       ack_hit;
  logic       cap;

  assign rise    = req & ~req_d;
  assign ack_hit = (state == PRESENT) && irq_ack;
  assign clr     = ack_hit ? (8'b1 << irq_id) : 8'h00;
  // a rise on a bit being acked this cycle is a fresh event, not an overrun
  assign ovr     = rise & pending & ~clr;
  assign cap     = (state == IDLE) && enc_valid;

  assign pend_vec  = pending & mask;
  assign irq_valid = (state == PRESENT);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (enc_valid) state_nx = PRESENT;
      PRESENT: if (irq_ack)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_d   <= 8'h00;
      pending <= 8'h00;
      ovf     <= 8'h00;
      irq_id  <= 3'd0;
    end else begin
      state   <= state_nx;
      req_d   <= req;
      // set wins over the ack clear
      pending <= (pending & ~clr) | rise;
      ovf     <= (ovf_clr ? 8'h00 : ovf) | ovr;
      if (cap) irq_id <= enc_out;
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Testbench for irq_pending_ctrl: behavioural model + directed vectors.
// Drives an ideal 8-to-3 priority encoder from pend_vec.
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic [7:0] pend_vec;
  logic [2:0] enc_out;
  logic       enc_valid;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic       irq_ack;
  logic [7:0] ovf;
  logic       ovf_clr;

  int n_pass = 0;
  int n_tot  = 0;

  irq_pending_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .mask     (mask),
    .pend_vec (pend_vec),
    .enc_out  (enc_out),
    .enc_valid(enc_valid),
    .irq_valid(irq_valid),
    .irq_id   (irq_id),
    .irq_ack  (irq_ack),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  always_comb begin
    enc_out   = 3'd0;
    enc_valid = |pend_vec;
    for (int i = 0; i < 8; i++)
      if (pend_vec[i]) enc_out = 3'(i);
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_tot++;
    if (a !== e)
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    else
      n_pass++;
  endtask

  // model state: plain bit arrays and an int ID
  bit m_reqd [8];
  bit m_pend [8];
  bit m_ovf  [8];
  bit m_pres;
  int m_id;

  function automatic logic [7:0] pack(input bit v [8]);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[i];
    return r;
  endfunction

  always @(posedge clk) begin
    bit np [8];
    bit no [8];
    int best;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_reqd[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
      end
      m_pres = 0;
      m_id   = 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        bit ev, gone;
        ev   = req[i] && !m_reqd[i];
        gone = m_pres && irq_ack && (i == m_id);
        np[i] = ev ? 1'b1 : (gone ? 1'b0 : m_pend[i]);
        no[i] = ev && m_pend[i] && !gone ? 1'b1
              : (ovf_clr ? 1'b0 : m_ovf[i]);
      end
      if (m_pres) begin
        if (irq_ack) m_pres = 0;
      end else begin
        best = -1;
        for (int i = 0; i < 8; i++)
          if (m_pend[i] && mask[i]) best = i;
        if (best >= 0) begin
          m_pres = 1;
          m_id   = best;
        end
      end
      for (int i = 0; i < 8; i++) begin
        m_pend[i] = np[i];
        m_ovf[i]  = no[i];
        m_reqd[i] = req[i];
      end
    end
    #1;
    chk("m_valid", 32'(irq_valid), 32'(m_pres));
    if (m_pres) chk("m_id", 32'(irq_id), 32'(m_id));
    chk("m_pend_vec", 32'(pend_vec), 32'(pack(m_pend) & mask));
    chk("m_ovf", 32'(ovf), 32'(pack(m_ovf)));
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 8'h00; mask = 8'hFF;
    irq_ack = 1'b0; ovf_clr = 1'b0;
    cyc(2);
    chk("rst_valid", 32'(irq_valid), 0);
    chk("rst_pend", 32'(pend_vec), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;
    cyc();

    // single event
    req = 8'h20; cyc();
    chk("single_pend", 32'(pend_vec), 32'h20);
    chk("single_valid0", 32'(irq_valid), 0);
    cyc();
    chk("single_valid", 32'(irq_valid), 1);
    chk("single_id", 32'(irq_id), 5);
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    chk("single_ack_pend", 32'(pend_vec), 0);
    chk("single_ack_valid", 32'(irq_valid), 0);
    req = 8'h00; cyc();

    // priority
    req = 8'h42; cyc(2);
    chk("prio_id1", 32'(irq_id), 6);
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    chk("prio_gap", 32'(irq_valid), 0);
    cyc();
    chk("prio_valid2", 32'(irq_valid), 1);
    chk("prio_id2", 32'(irq_id), 1);
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    req = 8'h00; cyc();

    // masking
    mask = 8'h00; req = 8'h08; cyc(3);
    chk("mask_valid", 32'(irq_valid), 0);
    chk("mask_pend", 32'(pend_vec), 0);
    mask = 8'h08; cyc();
    chk("mask_id", 32'(irq_id), 3);
    chk("mask_valid1", 32'(irq_valid), 1);
    mask = 8'h00; cyc();
    chk("mask_hold", 32'(irq_valid), 1);
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    mask = 8'hFF; req = 8'h00; cyc();
    chk("mask_cleared", 32'(pend_vec), 0);

    // overrun
    req = 8'h04; cyc();
    req = 8'h00; cyc();
    chk("ovr_id", 32'(irq_id), 2);
    req = 8'h04; cyc();
    chk("ovr_ovf", 32'(ovf), 32'h04);
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    cyc(2);
    chk("ovr_single", 32'(irq_valid), 0);
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
    chk("ovr_clr", 32'(ovf), 0);
    req = 8'h00; cyc();

    // set wins
    req = 8'h10; cyc(2);
    chk("sw_id", 32'(irq_id), 4);
    req = 8'h00; cyc();
    req = 8'h10; irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    chk("sw_pend", 32'(pend_vec), 32'h10);
    chk("sw_ovf", 32'(ovf), 0);
    chk("sw_gap", 32'(irq_valid), 0);
    cyc();
    chk("sw_re_id", 32'(irq_id), 4);
    chk("sw_re_valid", 32'(irq_valid), 1);
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    req = 8'h00; cyc();

    // ack in idle is ignored
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    chk("idle_ack", 32'(irq_valid), 0);

    // reset mid-present, line held high across release
    req = 8'h80; cyc(2);
    chk("rp_valid", 32'(irq_valid), 1);
    req = 8'h84; cyc();
    chk("rp_ovf_pre", 32'(ovf), 0);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("rp_valid0", 32'(irq_valid), 0);
    chk("rp_pend0", 32'(pend_vec), 0);
    chk("rp_ovf0", 32'(ovf), 0);
    cyc();
    chk("rp_rearm", 32'(pend_vec), 32'h84);
    cyc();
    chk("rp_id", 32'(irq_id), 7);
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
    req = 8'h00; cyc(3);

    // mixed traffic checked by the model only
    for (int i = 0; i < 300; i++) begin
      req     = 8'($urandom);
      mask    = 8'($urandom);
      irq_ack = 1'($urandom_range(0, 1));
      ovf_clr = ($urandom_range(0, 7) == 0);
      cyc();
    end
    irq_ack = 1'b0; ovf_clr = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
